// File: rtl/imem_loader.sv
// Streams 24-bit instructions from a byte host into instruction memory, then
// verifies an XOR checksum before releasing the processor from reset.
module imem_loader #(
    parameter logic [7:0] BASE = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  len,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  wa,
    output logic [23:0] wd,
    output logic        we,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

    state_t      state_reg, state_next;
    logic [8:0]  cnt_reg;
    logic [1:0]  bidx_reg;
    logic [7:0]  addr_reg;
    logic [7:0]  csum_reg;
    logic [7:0]  b0_reg, b1_reg;
    logic [7:0]  wa_reg;
    logic [23:0] wd_reg;
    logic        we_reg;
    logic        err_reg;
    logic        cpu_rst_reg;
    logic        accept;
    logic        start_ok;
    logic        word_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        start_ok   = 1'b0;
        case (state_reg)
            IDLE: begin
                start_ok = start;
                if (start) state_next = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && bidx_reg == 2'd2 && cnt_reg == 9'd1) state_next = CHECK;
            end
            CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_next = DONE;
            end
            DONE: begin
                done     = 1'b1;
                start_ok = start;
                if (start) state_next = LOAD;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept   = in_valid && in_ready;
    assign word_end = (bidx_reg == 2'd2);

    // Datapath: byte assembly, running checksum, registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= 9'd0;
            bidx_reg    <= 2'd0;
            addr_reg    <= 8'h00;
            csum_reg    <= 8'h00;
            b0_reg      <= 8'h00;
            b1_reg      <= 8'h00;
            wa_reg      <= 8'h00;
            wd_reg      <= 24'h0;
            we_reg      <= 1'b0;
            err_reg     <= 1'b0;
            cpu_rst_reg <= 1'b1;
        end else begin
            we_reg <= 1'b0;
            if (start_ok) begin
                // len of zero encodes a full 256-word image
                cnt_reg     <= (len == 8'h00) ? 9'd256 : {1'b0, len};
                bidx_reg    <= 2'd0;
                addr_reg    <= BASE;
                csum_reg    <= 8'h00;
                err_reg     <= 1'b0;
                cpu_rst_reg <= 1'b1;
            end else if (accept && state_reg == LOAD) begin
                csum_reg <= csum_reg ^ in_data;
                case (bidx_reg)
                    2'd0: begin
                        b0_reg   <= in_data;
                        bidx_reg <= 2'd1;
                    end
                    2'd1: begin
                        b1_reg   <= in_data;
                        bidx_reg <= 2'd2;
                    end
                    default: begin
                        bidx_reg <= 2'd0;
                    end
                endcase
                if (word_end) begin
                    we_reg   <= 1'b1;
                    wa_reg   <= addr_reg;
                    wd_reg   <= {b0_reg, b1_reg, in_data};
                    addr_reg <= addr_reg + 8'd1;
                    cnt_reg  <= cnt_reg - 9'd1;
                end
            end else if (accept && state_reg == CHECK) begin
                err_reg     <= (in_data != csum_reg);
                cpu_rst_reg <= (in_data != csum_reg);
            end
        end
    end

    assign wa      = wa_reg;
    assign wd      = wd_reg;
    assign we      = we_reg;
    assign err     = err_reg;
    assign cpu_rst = cpu_rst_reg;

endmodule
